servo_pwm_gen: RTL and testbench
================================

// Module: servo_pwm_gen
// PURPOSE
//  Multi-channel hobby-servo pulse generator driving the SoM gpio servo pins from top.
//  Accepts per-channel position commands over a valid/ready port and emits one pulse per
//  channel per 20 ms frame. Widths change only at frame boundaries, so pulses are never truncated.
// PARAMETERS
//  CLK_HZ       50_000_000  system clock frequency; CLK_HZ/1_000_000 must be an integer >= 2
//  NUM_CH       3           number of servo channels (1..4)
//  FRAME_US     20000       frame period in microseconds
//  MIN_US       1000        pulse width for position 0
//  SLEW_STEP_US 100         max width change per frame (used only with SERVO_SLEW_EN)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  enable     in   1       level; 1 = generate frames
//  cmd_valid  in   1       position command valid
//  cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//  cmd_ch     in   2       target channel index
//  cmd_pos    in   10      position 0..1000 -> width MIN_US+cmd_pos us; >1000 clamps to 1000
//  pwm        out  NUM_CH  servo pulse outputs
//  frame_start out 1       one-clk strobe on the first cycle of each frame
//  active     out  1       1 while in RUN or DRAIN
// BEHAVIOUR
//  Reset (async): pwm=0, frame_start=0, active=0, cmd_ready=0, state=DISABLED, every target and
//   shadow width = MIN_US+500 (1500 us); prescaler and us counter = 0.
//  Timebase: prescaler emits us_tick every CLK_HZ/1e6 clks; us_cnt counts 0..FRAME_US-1 on us_tick, wraps.
//  cmd_ready=1 every cycle after reset release. On accept: target[cmd_ch] <= MIN_US+min(cmd_pos,1000),
//   registered on the same edge. cmd_ch >= NUM_CH: command accepted and dropped.
//  Frame boundary: us_tick with us_cnt==FRAME_US-1 (or the DISABLED->RUN entry edge). On that edge
//   shadow[i] <= target[i] (pre-edge value); frame_start is high for the following single clk.
//   A command accepted on the boundary edge itself takes effect in the next frame.
//  pwm[i] = (state!=DISABLED) && (us_cnt < shadow[i]); registered output, 1 clk after us_cnt.
//  FSM:
//   DISABLED: us_cnt and prescaler held at 0, pwm=0. enable=1 -> RUN (frame boundary taken).
//   RUN: enable=0 -> DRAIN; otherwise loop.
//   DRAIN: finish current frame; at frame boundary -> DISABLED if enable=0, else stay RUN.
//   enable re-asserted in DRAIN -> RUN without restarting the frame.
//  Width arithmetic: 15-bit unsigned us; shadow always in [MIN_US, MIN_US+1000].
//  Reset mid-pulse: pwm drops to 0 immediately (async); no partial pulse resumes after release.
// CONFIGURATION
//  SERVO_SLEW_EN defined: at each frame boundary shadow[i] moves toward target[i] by at most
//   SLEW_STEP_US (no overshoot). Not defined: shadow[i] <= target[i] directly; SLEW_STEP_US unused.
// STRUCTURE
//  Package servo_pkg: state enum {DISABLED,RUN,DRAIN}, width type (logic [14:0]), POS_MAX=1000,
//   center constant, clamp function.
//  Sub-module servo_us_tick: prescaler producing the one-clk us_tick strobe; rest is in this file.
// TESTING (CLK_HZ=50e6: 1 us = 50 clks, frame = 1_000_000 clks)
//  Reset release, enable=1, no commands -> all pwm pulses 75_000 clks high every 1_000_000 clks.
//  cmd ch1 pos=0 at us 700 -> current ch1 pulse stays 1500 us; next frame 50_000 clks; ch0/ch2 unchanged.
//  cmd ch2 pos=1023 -> clamped to 2000 us (100_000 clks); cmd_ch=3 with NUM_CH=3 -> no channel changes.
//  enable=0 at us 500 -> pulse completes 1500 us, active falls at frame end, pwm stays 0 afterwards.
//  cmd accepted on boundary edge -> width unchanged this frame, applied next frame.
//  SERVO_SLEW_EN, step 100, target 1500->2000 -> widths 1600,1700,1800,1900,2000 over 5 frames;
//   without macro the first frame after the write is 2000 us. rst_n low mid-pulse -> pwm 0 same cycle.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and helpers for the hobby-servo pulse generator.
package servo_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } servo_state_t;

  // Pulse widths and the microsecond counter are plain unsigned microseconds.
  typedef logic [14:0] width_t;

  localparam int POS_MAX    = 1000;
  localparam int POS_CENTER = 500;

  localparam logic [9:0] POS_MAX_V = 10'(POS_MAX);

  // Position command to pulse width; positions above full travel saturate.
  function automatic width_t clamp_width(input logic [9:0] pos, input width_t min_w);
    logic [9:0] p;
    p = (pos > POS_MAX_V) ? POS_MAX_V : pos;
    return min_w + width_t'(p);
  endfunction

endpackage

// File: rtl/servo_us_tick.sv
// Microsecond prescaler: one-clock us_tick strobe every DIV clocks.
// While clear is high the prescaler is parked at zero and no tick is produced,
// so the first tick after clear falls comes exactly DIV clocks later.
module servo_us_tick
  import servo_pkg::*;
#(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic us_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] pre_cnt;
  logic          wrap;

  assign wrap    = (pre_cnt == LAST);
  assign us_tick = wrap && !clear;

  // Free-running divide-by-DIV counter, held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clear || wrap) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Multi-channel hobby-servo pulse generator.
// One pulse per channel per frame; commanded widths are latched into the
// per-channel shadow registers only at frame boundaries, so a pulse in flight
// is never shortened or stretched.
// Build option: define SERVO_SLEW_EN to rate-limit each channel's width change
// to SLEW_STEP_US per frame; otherwise the shadow jumps straight to the target.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int NUM_CH       = 3,
  parameter int FRAME_US     = 20000,
  parameter int MIN_US       = 1000,
  parameter int SLEW_STEP_US = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ch,
  input  logic [9:0]        cmd_pos,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_start,
  output logic              active
);

  localparam int     DIV      = CLK_HZ / 1_000_000;
  localparam width_t MIN_W    = width_t'(MIN_US);
  localparam width_t CENTER_W = width_t'(MIN_US + POS_CENTER);
  localparam width_t LAST_US  = width_t'(FRAME_US - 1);

`ifdef SERVO_SLEW_EN
  localparam width_t STEP_W = width_t'(SLEW_STEP_US);
`else
  // A step at least as large as full travel turns the slew into a direct load.
  localparam width_t STEP_W = width_t'((SLEW_STEP_US > POS_MAX) ? SLEW_STEP_US : POS_MAX);
`endif

  // Move cur toward tgt by at most STEP_W, never past tgt.
  function automatic width_t slew_toward(input width_t cur, input width_t tgt);
    width_t w;
    if (tgt > cur) begin
      w = ((tgt - cur) > STEP_W) ? (cur + STEP_W) : tgt;
    end else begin
      w = ((cur - tgt) > STEP_W) ? (cur - STEP_W) : tgt;
    end
    return w;
  endfunction

  servo_state_t state;
  servo_state_t state_nxt;

  logic   tick_hold;
  logic   us_tick;
  logic   frame_end;
  logic   new_frame;
  logic   accept;
  logic   rdy_q;
  width_t us_cnt;
  width_t target [NUM_CH];
  width_t shadow [NUM_CH];

  logic [NUM_CH-1:0] pwm_p1;
  logic              frame_start_p1;

  assign tick_hold = (state == DISABLED);

  servo_us_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tick_hold),
    .us_tick (us_tick)
  );

  assign frame_end = us_tick && (us_cnt == LAST_US);
  assign accept    = cmd_valid && rdy_q;

  // Next-state logic; new_frame marks every edge on which a frame begins.
  always_comb begin
    state_nxt = state;
    new_frame = 1'b0;
    case (state)
      DISABLED: begin
        if (enable) begin
          state_nxt = RUN;
          new_frame = 1'b1;
        end
      end
      RUN: begin
        new_frame = frame_end;
        if (!enable) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (enable) begin
          state_nxt = RUN;
          new_frame = frame_end;
        end else if (frame_end) begin
          state_nxt = DISABLED;
        end
      end
      default: begin
        state_nxt = DISABLED;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DISABLED;
    end else begin
      state <= state_nxt;
    end
  end

  // Microsecond position within the frame; parked at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt <= '0;
    end else if (state == DISABLED) begin
      us_cnt <= '0;
    end else if (us_tick) begin
      us_cnt <= frame_end ? '0 : (us_cnt + 15'd1);
    end
  end

  // Command port is always ready once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // Capture commanded widths; commands for channels that do not exist are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= CENTER_W;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && (cmd_ch == 2'(i))) begin
          target[i] <= clamp_width(cmd_pos, MIN_W);
        end
      end
    end
  end

  // Latch the width used for the whole coming frame from the pre-edge target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= CENTER_W;
      end
    end else if (new_frame) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= slew_toward(shadow[i], target[i]);
      end
    end
  end

  // Output stage p1: registered pulse compare and frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p1         <= '0;
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= new_frame;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_p1[i] <= (state != DISABLED) && (us_cnt < shadow[i]);
      end
    end
  end

  assign pwm         = pwm_p1;
  assign frame_start = frame_start_p1;
  assign active      = (state != DISABLED);
  assign cmd_ready   = rdy_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Testbench for servo_pwm_gen with a shortened timebase (2 clocks per us,
// 1200 us frame, 100 us minimum width) so a frame is 2400 clocks.
module tb_servo_pwm_gen;

  localparam int CLK_HZ   = 2_000_000;
  localparam int NUM_CH   = 3;
  localparam int FRAME_US = 1200;
  localparam int MIN_US   = 100;
  localparam int SLEW_US  = 100;
  localparam int DIV      = 2;
  localparam int F        = FRAME_US * DIV;
`ifdef SERVO_SLEW_EN
  localparam int STEP_US = SLEW_US;
`else
  localparam int STEP_US = 1000;
`endif

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_ch;
  logic [9:0]        cmd_pos;
  logic [NUM_CH-1:0] pwm;
  logic              frame_start;
  logic              active;

  servo_pwm_gen #(
    .CLK_HZ       (CLK_HZ),
    .NUM_CH       (NUM_CH),
    .FRAME_US     (FRAME_US),
    .MIN_US       (MIN_US),
    .SLEW_STEP_US (SLEW_US)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ch      (cmd_ch),
    .cmd_pos     (cmd_pos),
    .pwm         (pwm),
    .frame_start (frame_start),
    .active      (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: commanded target and per-frame width, in microseconds.
  int tgt  [NUM_CH];
  int shd  [NUM_CH];
  int meas [NUM_CH];
  int prev [NUM_CH];

  typedef struct {
    int ch;
    int pos;
    int exp_us;
  } vec_t;

  vec_t vecs [7];
  int   slew_seq [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_us(input int pos);
    return MIN_US + ((pos > 1000) ? 1000 : pos);
  endfunction

  function automatic int slew(input int s, input int t);
    if (t > s) return ((t - s) > STEP_US) ? (s + STEP_US) : t;
    return ((s - t) > STEP_US) ? (s - STEP_US) : t;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      tgt[c] = MIN_US + 500;
      shd[c] = MIN_US + 500;
    end
  endtask

  task automatic model_cmd(input int ch, input int pos);
    if (ch < NUM_CH) tgt[ch] = clamp_us(pos);
  endtask

  task automatic model_boundary();
    for (int c = 0; c < NUM_CH; c++) shd[c] = slew(shd[c], tgt[c]);
  endtask

  // Called just after a frame_start sample; measures one frame up to the next
  // frame_start, optionally issuing a command at sample `at` and toggling enable.
  task automatic run_frame(input bit do_cmd, input int ch, input int pos, input int at,
                           input int off_at, input int on_at);
    int hi [NUM_CH];
    int n;
    bit seen;
    for (int c = 0; c < NUM_CH; c++) begin
      hi[c]   = 0;
      prev[c] = meas[c];
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && (n < 2 * F)) begin
      @(negedge clk);
      n++;
      for (int c = 0; c < NUM_CH; c++) if (pwm[c]) hi[c]++;
      if (frame_start) seen = 1'b1;
      cmd_valid = 1'b0;
      if (do_cmd && (n == at)) begin
        cmd_valid = 1'b1;
        cmd_ch    = 2'(ch);
        cmd_pos   = 10'(pos);
      end
      if (n == off_at) enable = 1'b0;
      if (n == on_at) enable = 1'b1;
    end
    chk("frame_len", n, F);
    for (int c = 0; c < NUM_CH; c++) begin
      meas[c] = hi[c] / DIV;
      chk($sformatf("width_ch%0d", c), hi[c], shd[c] * DIV);
    end
    // A command accepted on the boundary edge only reaches the frame after next.
    if (do_cmd && (at < F - 1)) model_cmd(ch, pos);
    model_boundary();
    if (do_cmd && (at >= F - 1)) model_cmd(ch, pos);
  endtask

  initial begin
    int bad;
    int hi0;

    vecs[0] = '{0, 0, 100};
    vecs[1] = '{1, 250, 350};
    vecs[2] = '{2, 1023, 1100};
    vecs[3] = '{3, 10, -1};
    vecs[4] = '{0, 1000, 1100};
    vecs[5] = '{2, 1001, 1100};
    vecs[6] = '{1, 999, 1099};
`ifdef SERVO_SLEW_EN
    slew_seq = '{700, 800, 900, 1000, 1100};
`else
    slew_seq = '{1100, 1100, 1100, 1100, 1100};
`endif

    rst_n     = 1'b0;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    cmd_ch    = 2'd0;
    cmd_pos   = 10'd0;
    model_reset();
    for (int c = 0; c < NUM_CH; c++) meas[c] = 0;

    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_frame_start", int'(frame_start), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_ready", int'(cmd_ready), 0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(cmd_ready), 1);
    chk("idle_active", int'(active), 0);
    repeat (5) @(negedge clk);
    chk("idle_pwm", int'(pwm), 0);

    // Enable: the entry edge is itself a frame boundary.
    enable = 1'b1;
    @(negedge clk);
    chk("entry_strobe", int'(frame_start), 1);
    chk("entry_active", int'(active), 1);
    model_boundary();

    // Centre widths this frame; ch1 commanded to full travel at 700 us.
    run_frame(1'b1, 1, 1000, 700 * DIV, 0, 0);
    for (int k = 0; k < 5; k++) begin
      run_frame(1'b0, 0, 0, 0, 0, 0);
      chk("slew_ch1", meas[1], slew_seq[k]);
    end

    // Table of commands, each checked in the frame after it is issued.
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) run_frame(1'b1, vecs[i].ch, vecs[i].pos, 700 * DIV, 0, 0);
      else run_frame(1'b0, 0, 0, 0, 0, 0);
`ifndef SERVO_SLEW_EN
      if (i > 0) begin
        if (vecs[i-1].ch < NUM_CH) begin
          chk("table_width", meas[vecs[i-1].ch], vecs[i-1].exp_us);
        end else begin
          for (int c = 0; c < NUM_CH; c++) chk("table_drop", meas[c], prev[c]);
        end
      end
`endif
    end

    // Command accepted exactly on the boundary edge.
    run_frame(1'b1, 0, 0, F - 1, 0, 0);
    run_frame(1'b0, 0, 0, 0, 0, 0);
`ifndef SERVO_SLEW_EN
    chk("boundary_same", meas[0], 1100);
`endif
    run_frame(1'b0, 0, 0, 0, 0, 0);
`ifndef SERVO_SLEW_EN
    chk("boundary_next", meas[0], 100);
`endif

    // enable bounce inside a frame: DRAIN back to RUN without restarting.
    run_frame(1'b0, 0, 0, 0, 250 * DIV, 450 * DIV);
    chk("bounce_active", int'(active), 1);

    // Randomized commands against the model.
    for (int k = 0; k < 5; k++) begin
      run_frame(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                int'($urandom_range(2, F - 3)), 0, 0);
    end
    run_frame(1'b0, 0, 0, 0, 0, 0);

    // Disable mid-frame: pulse completes, frame finishes, then idle.
    hi0 = 0;
    for (int n = 1; n <= F; n++) begin
      @(negedge clk);
      if (pwm[0]) hi0++;
      if (n == 500 * DIV) enable = 1'b0;
      if (n == F - 1) chk("drain_active_before", int'(active), 1);
      if (n == F) begin
        chk("drain_active_after", int'(active), 0);
        chk("drain_no_strobe", int'(frame_start), 0);
      end
    end
    chk("drain_width", hi0, shd[0] * DIV);
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if ((pwm != '0) || frame_start || active) bad++;
    end
    chk("drain_idle", bad, 0);

    // Reset asserted in the middle of a pulse.
    enable = 1'b1;
    @(negedge clk);
    chk("reentry_strobe", int'(frame_start), 1);
    model_boundary();
    repeat (20) @(negedge clk);
    chk("pre_reset_pwm", int'(pwm), (1 << NUM_CH) - 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_pwm", int'(pwm), 0);
    chk("async_reset_active", int'(active), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (pwm != '0) bad++;
    end
    chk("post_reset_idle", bad, 0);

    enable = 1'b1;
    @(negedge clk);
    chk("restart_strobe", int'(frame_start), 1);
    model_boundary();
    run_frame(1'b0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
